// File: rtl/core_mmu_arbiter.sv
// core_mmu_arbiter: round-robin share of the MMU page-walk port between
// insn fetch and data access; per-port pending slots, fault copy.
// Ports: clk, rst (async, active-high); insn_* fetch port; data_* data
// port; pw_* walker port; fault_* registered copy of the last fault.
module core_mmu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        insn_start,
  input  logic [29:0] insn_addr,
  output logic        insn_ready,
  output logic        insn_fault,
  output logic [31:0] insn_data_rd,
  input  logic        data_start,
  input  logic [29:0] data_addr,
  input  logic        data_write,
  input  logic [31:0] data_data_wr,
  input  logic [3:0]  data_data_be,
  output logic        data_ready,
  output logic        data_fault,
  output logic [31:0] data_data_rd,
  output logic        pw_start,
  output logic [29:0] pw_addr,
  output logic        pw_write,
  output logic [31:0] pw_data_wr,
  output logic [3:0]  pw_data_be,
  input  logic        pw_ready,
  input  logic        pw_fault,
  input  logic        pw_fault_page,
  input  logic [31:0] pw_data_rd,
  input  logic [29:0] pw_fault_addr,
  input  logic [3:0]  pw_fault_type,
  input  logic [3:0]  pw_fault_domain,
  output logic        fault_insn,
  output logic        fault_page,
  output logic [29:0] fault_addr,
  output logic [3:0]  fault_type,
  output logic [3:0]  fault_domain
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state, state_nx;

  logic        last_d;
  logic        ins_pend;
  logic [29:0] ins_addr;
  logic        dat_pend;
  logic [29:0] dat_addr;
  logic        dat_write;
  logic [31:0] dat_wr;
  logic [3:0]  dat_be;

  logic busy_i, busy_d, done, can_grant;
  logic ins_take, dat_take, ins_req, dat_req;
  logic grant_i, grant_d;

  logic [29:0] ins_src_addr;
  logic [29:0] dat_src_addr;
  logic        dat_src_write;
  logic [31:0] dat_src_wr;
  logic [3:0]  dat_src_be;

  assign busy_i    = (state == BUSY_I);
  assign busy_d    = (state == BUSY_D);
  assign done      = pw_ready & (busy_i | busy_d);
  assign can_grant = (state == IDLE) | done;

  // A port's slot is free when nothing is pending and it does not own
  // an unfinished walk; a ready this cycle frees the owning port.
  assign ins_take = insn_start & ~ins_pend & ~(busy_i & ~pw_ready);
  assign dat_take = data_start & ~dat_pend & ~(busy_d & ~pw_ready);
  assign ins_req  = ins_pend | ins_take;
  assign dat_req  = dat_pend | dat_take;

  // Same-cycle starts bypass the slot registers.
  assign ins_src_addr  = ins_pend ? ins_addr  : insn_addr;
  assign dat_src_addr  = dat_pend ? dat_addr  : data_addr;
  assign dat_src_write = dat_pend ? dat_write : data_write;
  assign dat_src_wr    = dat_pend ? dat_wr    : data_data_wr;
  assign dat_src_be    = dat_pend ? dat_be    : data_data_be;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Completion hands the walker straight to the next pending port.
  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    if (can_grant) begin
      if (ins_req && dat_req) begin
        grant_i = last_d;
        grant_d = ~last_d;
      end else begin
        grant_i = ins_req;
        grant_d = dat_req;
      end
      if (grant_i)      state_nx = BUSY_I;
      else if (grant_d) state_nx = BUSY_D;
      else              state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_pend  <= 1'b0;
      ins_addr  <= '0;
      dat_pend  <= 1'b0;
      dat_addr  <= '0;
      dat_write <= 1'b0;
      dat_wr    <= '0;
      dat_be    <= '0;
      last_d    <= 1'b0;
    end else begin
      ins_pend <= ins_req & ~grant_i;
      dat_pend <= dat_req & ~grant_d;
      if (ins_take) ins_addr <= insn_addr;
      if (dat_take) begin
        dat_addr  <= data_addr;
        dat_write <= data_write;
        dat_wr    <= data_data_wr;
        dat_be    <= data_data_be;
      end
      if (grant_i) last_d <= 1'b0;
      if (grant_d) last_d <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pw_start   <= 1'b0;
      pw_addr    <= '0;
      pw_write   <= 1'b0;
      pw_data_wr <= '0;
      pw_data_be <= '0;
    end else begin
      pw_start <= grant_i | grant_d;
      if (grant_i) begin
        pw_addr    <= ins_src_addr;
        pw_write   <= 1'b0;
        pw_data_be <= 4'hF;
      end else if (grant_d) begin
        pw_addr    <= dat_src_addr;
        pw_write   <= dat_src_write;
        pw_data_wr <= dat_src_wr;
        pw_data_be <= dat_src_be;
      end else if (done) begin
        pw_write <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_insn   <= 1'b0;
      fault_page   <= 1'b0;
      fault_addr   <= '0;
      fault_type   <= '0;
      fault_domain <= '0;
    end else if (done && pw_fault) begin
      fault_insn   <= busy_i;
      fault_page   <= pw_fault_page;
      fault_addr   <= pw_fault_addr;
      fault_type   <= pw_fault_type;
      fault_domain <= pw_fault_domain;
    end
  end

  assign insn_ready   = pw_ready & busy_i;
  assign insn_fault   = pw_fault & busy_i;
  assign data_ready   = pw_ready & busy_d;
  assign data_fault   = pw_fault & busy_d;
  assign insn_data_rd = pw_data_rd;
  assign data_data_rd = pw_data_rd;

endmodule

// File: tb/tb_core_mmu_arbiter.sv
// tb_core_mmu_arbiter: directed and random checks of core_mmu_arbiter
// against a transaction-level model of requests, grants and faults.
module tb_core_mmu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        insn_start = 1'b0;
  logic [29:0] insn_addr = '0;
  logic        insn_ready, insn_fault;
  logic [31:0] insn_data_rd;
  logic        data_start = 1'b0;
  logic [29:0] data_addr = '0;
  logic        data_write = 1'b0;
  logic [31:0] data_data_wr = '0;
  logic [3:0]  data_data_be = '0;
  logic        data_ready, data_fault;
  logic [31:0] data_data_rd;
  logic        pw_start;
  logic [29:0] pw_addr;
  logic        pw_write;
  logic [31:0] pw_data_wr;
  logic [3:0]  pw_data_be;
  logic        pw_ready = 1'b0;
  logic        pw_fault = 1'b0;
  logic        pw_fault_page = 1'b0;
  logic [31:0] pw_data_rd = '0;
  logic [29:0] pw_fault_addr = '0;
  logic [3:0]  pw_fault_type = '0;
  logic [3:0]  pw_fault_domain = '0;
  logic        fault_insn, fault_page;
  logic [29:0] fault_addr;
  logic [3:0]  fault_type, fault_domain;

  core_mmu_arbiter dut (
    .clk(clk), .rst(rst),
    .insn_start(insn_start), .insn_addr(insn_addr),
    .insn_ready(insn_ready), .insn_fault(insn_fault),
    .insn_data_rd(insn_data_rd),
    .data_start(data_start), .data_addr(data_addr),
    .data_write(data_write), .data_data_wr(data_data_wr),
    .data_data_be(data_data_be),
    .data_ready(data_ready), .data_fault(data_fault),
    .data_data_rd(data_data_rd),
    .pw_start(pw_start), .pw_addr(pw_addr), .pw_write(pw_write),
    .pw_data_wr(pw_data_wr), .pw_data_be(pw_data_be),
    .pw_ready(pw_ready), .pw_fault(pw_fault),
    .pw_fault_page(pw_fault_page), .pw_data_rd(pw_data_rd),
    .pw_fault_addr(pw_fault_addr), .pw_fault_type(pw_fault_type),
    .pw_fault_domain(pw_fault_domain),
    .fault_insn(fault_insn), .fault_page(fault_page),
    .fault_addr(fault_addr), .fault_type(fault_type),
    .fault_domain(fault_domain)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: which port owns the walker, which port
  // holds an accepted request, what the walker was last asked for.
  typedef struct {
    logic        valid;
    logic [29:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  localparam int NONE = 0;
  localparam int INSN = 1;
  localparam int DATA = 2;

  req_t        slot [1:2];
  int          owner;
  int          last_port;
  logic        e_start;
  req_t        e_req;
  logic        f_insn, f_page;
  logic [29:0] f_addr;
  logic [3:0]  f_type, f_dom;

  bit wact;
  int wcnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 1; p <= 2; p++) slot[p] = '{1'b0, '0, 1'b0, '0, '0};
    owner     = NONE;
    last_port = INSN;
    e_start   = 1'b0;
    e_req     = '{1'b0, '0, 1'b0, '0, '0};
    f_insn    = 1'b0;
    f_page    = 1'b0;
    f_addr    = '0;
    f_type    = '0;
    f_dom     = '0;
  endtask

  task automatic model_step();
    bit done;
    int pick;
    if (rst) begin
      model_reset();
      return;
    end
    done = pw_ready && owner != NONE;
    if (done && pw_fault) begin
      f_insn = (owner == INSN);
      f_page = pw_fault_page;
      f_addr = pw_fault_addr;
      f_type = pw_fault_type;
      f_dom  = pw_fault_domain;
    end
    if (insn_start && !slot[INSN].valid &&
        !(owner == INSN && !pw_ready))
      slot[INSN] = '{1'b1, insn_addr, 1'b0, '0, 4'hF};
    if (data_start && !slot[DATA].valid &&
        !(owner == DATA && !pw_ready))
      slot[DATA] = '{1'b1, data_addr, data_write,
                     data_data_wr, data_data_be};
    e_start = 1'b0;
    if (owner == NONE || done) begin
      pick = NONE;
      if (slot[INSN].valid && slot[DATA].valid)
        pick = (last_port == INSN) ? DATA : INSN;
      else if (slot[INSN].valid) pick = INSN;
      else if (slot[DATA].valid) pick = DATA;
      if (pick != NONE) begin
        e_start    = 1'b1;
        e_req.addr = slot[pick].addr;
        e_req.be   = slot[pick].be;
        e_req.write = slot[pick].write;
        if (pick == DATA) e_req.wdata = slot[pick].wdata;
        slot[pick].valid = 1'b0;
        last_port = pick;
      end else if (done) begin
        e_req.write = 1'b0;
      end
      owner = pick;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("pw_start", 32'(pw_start), 32'(e_start));
    chk("pw_addr", 32'(pw_addr), 32'(e_req.addr));
    chk("pw_write", 32'(pw_write), 32'(e_req.write));
    chk("pw_data_wr", pw_data_wr, e_req.wdata);
    chk("pw_data_be", 32'(pw_data_be), 32'(e_req.be));
    chk("insn_ready", 32'(insn_ready), 32'(pw_ready && owner == INSN));
    chk("insn_fault", 32'(insn_fault), 32'(pw_fault && owner == INSN));
    chk("data_ready", 32'(data_ready), 32'(pw_ready && owner == DATA));
    chk("data_fault", 32'(data_fault), 32'(pw_fault && owner == DATA));
    chk("insn_data_rd", insn_data_rd, pw_data_rd);
    chk("data_data_rd", data_data_rd, pw_data_rd);
    chk("fault_insn", 32'(fault_insn), 32'(f_insn));
    chk("fault_page", 32'(fault_page), 32'(f_page));
    chk("fault_addr", 32'(fault_addr), 32'(f_addr));
    chk("fault_type", 32'(fault_type), 32'(f_type));
    chk("fault_domain", 32'(fault_domain), 32'(f_dom));
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
    insn_start = 1'b0;
    data_start = 1'b0;
    pw_ready   = 1'b0;
    pw_fault   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    wact = 1'b0;
    sample();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    int ngr, cyc, obs, owner_obs;

    // Reset state
    do_reset();
    sample();
    chk("rst_pw_be", 32'(pw_data_be), 32'h0);
    advance();

    // Single insn walk
    insn_start = 1'b1;
    insn_addr  = 30'h100;
    sample(); advance();
    sample();
    chk("i_pw_start", 32'(pw_start), 32'h1);
    chk("i_pw_addr", 32'(pw_addr), 32'h100);
    chk("i_pw_write", 32'(pw_write), 32'h0);
    chk("i_pw_be", 32'(pw_data_be), 32'hF);
    advance();
    pw_ready   = 1'b1;
    pw_data_rd = 32'hE3A00001;
    sample();
    chk("i_ready", 32'(insn_ready), 32'h1);
    chk("i_rd", insn_data_rd, 32'hE3A00001);
    chk("i_d_ready", 32'(data_ready), 32'h0);
    advance();
    sample();
    chk("i_one_shot", 32'(pw_start), 32'h0);
    advance();

    // Simultaneous starts after reset: data first
    do_reset();
    insn_start   = 1'b1;
    insn_addr    = 30'h100;
    data_start   = 1'b1;
    data_addr    = 30'h200;
    data_write   = 1'b1;
    data_data_wr = 32'hDEADBEEF;
    data_data_be = 4'h3;
    sample(); advance();
    sample();
    chk("s_d_addr", 32'(pw_addr), 32'h200);
    chk("s_d_write", 32'(pw_write), 32'h1);
    chk("s_d_wr", pw_data_wr, 32'hDEADBEEF);
    chk("s_d_be", 32'(pw_data_be), 32'h3);
    advance();
    pw_ready = 1'b1;
    sample();
    chk("s_d_ready", 32'(data_ready), 32'h1);
    advance();
    sample();
    chk("s_i_start", 32'(pw_start), 32'h1);
    chk("s_i_addr", 32'(pw_addr), 32'h100);
    chk("s_i_write", 32'(pw_write), 32'h0);
    advance();
    pw_ready = 1'b1;
    sample(); advance();
    sample(); advance();

    // Back-to-back round robin over six walks
    do_reset();
    ngr = 0;
    cyc = 0;
    owner_obs = NONE;
    data_write = 1'b0;
    while (ngr < 6 && cyc < 40) begin
      pw_ready   = wact;
      insn_addr  = 30'h111;
      data_addr  = 30'h222;
      insn_start = (cyc == 0) || (wact && owner_obs == INSN);
      data_start = (cyc == 0) || (wact && owner_obs == DATA);
      sample();
      if (pw_start) begin
        obs = (pw_addr == 30'h222) ? DATA : INSN;
        chk("rr_order", 32'(obs), 32'((ngr % 2 == 0) ? DATA : INSN));
        owner_obs = obs;
        ngr++;
      end
      wact = pw_start;
      advance();
      cyc++;
    end
    chk("rr_count", 32'(ngr), 32'd6);

    // Data fault, then clean insn walk keeps the fault copy
    do_reset();
    data_start = 1'b1;
    data_addr  = 30'h3FF;
    data_write = 1'b0;
    sample(); advance();
    sample(); advance();
    pw_ready        = 1'b1;
    pw_fault        = 1'b1;
    pw_fault_type   = 4'd3;
    pw_fault_domain = 4'd5;
    pw_fault_page   = 1'b1;
    pw_fault_addr   = 30'h3FF;
    sample();
    chk("f_d_fault", 32'(data_fault), 32'h1);
    chk("f_d_ready", 32'(data_ready), 32'h1);
    chk("f_i_fault", 32'(insn_fault), 32'h0);
    advance();
    insn_start = 1'b1;
    insn_addr  = 30'h040;
    sample(); advance();
    sample(); advance();
    pw_ready = 1'b1;
    sample(); advance();
    sample();
    chk("f_insn", 32'(fault_insn), 32'h0);
    chk("f_addr", 32'(fault_addr), 32'h3FF);
    chk("f_type", 32'(fault_type), 32'h3);
    chk("f_dom", 32'(fault_domain), 32'h5);
    advance();

    // Reset mid BUSY_D with insn pending
    data_start = 1'b1;
    data_addr  = 30'h0AA;
    sample(); advance();
    insn_start = 1'b1;
    insn_addr  = 30'h0BB;
    sample(); advance();
    rst = 1'b1;
    pw_ready = 1'b1;
    model_reset();
    sample();
    chk("r_pw_start", 32'(pw_start), 32'h0);
    chk("r_d_ready", 32'(data_ready), 32'h0);
    chk("r_i_ready", 32'(insn_ready), 32'h0);
    advance();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("r_no_replay", 32'(pw_start), 32'h0);
      advance();
    end

    // Second data start while busy is ignored
    data_start = 1'b1;
    data_addr  = 30'h040;
    sample(); advance();
    sample(); advance();
    data_start = 1'b1;
    data_addr  = 30'h080;
    sample(); advance();
    sample();
    chk("x_addr_hold", 32'(pw_addr), 32'h040);
    advance();
    pw_ready = 1'b1;
    sample(); advance();
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("x_no_walk", 32'(pw_start), 32'h0);
      advance();
    end

    // Random traffic with a walker of random latency
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      insn_start      = ($urandom_range(0, 2) == 0);
      insn_addr       = 30'($urandom);
      data_start      = ($urandom_range(0, 2) == 0);
      data_addr       = 30'($urandom);
      data_write      = 1'($urandom);
      data_data_wr    = $urandom;
      data_data_be    = 4'($urandom);
      pw_data_rd      = $urandom;
      pw_fault_page   = 1'($urandom);
      pw_fault_addr   = 30'($urandom);
      pw_fault_type   = 4'($urandom);
      pw_fault_domain = 4'($urandom);
      if (wact && wcnt == 0) begin
        pw_ready = 1'b1;
        pw_fault = ($urandom_range(0, 3) == 0);
        wact = 1'b0;
      end else if (wact) begin
        wcnt--;
      end else begin
        pw_ready = ($urandom_range(0, 9) == 0);
      end
      if (rst) begin
        model_reset();
        wact = 1'b0;
      end
      sample();
      if (pw_start && !rst) begin
        wact = 1'b1;
        wcnt = $urandom_range(0, 3);
      end
      advance();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
